// File: rtl/edge_frame_writer.sv
// edge_frame_writer: packs 16 edge pixels into each 128-bit word and writes the words to DDR3,
// one frame of WIDTH*HEIGHT pixels at a time starting at BASE_ADDR.
module edge_frame_writer #(
    parameter int          WIDTH     = 1280,
    parameter int          HEIGHT    = 720,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    output logic         in_rd_en,
    input  logic         in_empty,
    input  logic [7:0]   in_dout,
    output logic [31:0]  sdram_address,
    output logic         wr_en,
    output logic [127:0] write_data_input,
    input  logic         write_complete,
    output logic         frame_done
);
    localparam int WORDS = WIDTH * HEIGHT / 16;
    localparam int WCW   = WORDS > 1 ? $clog2(WORDS) : 1;

    typedef enum logic {FILL, WRITE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     pix_cnt_q, pix_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [127:0]   data_q, data_d;
    logic           frame_done_q, frame_done_d;
    logic           pop, ack, last_word;

    assign pop       = state_q == FILL && !in_empty && !reset;
    assign ack       = state_q == WRITE && write_complete;
    assign last_word = word_cnt_q == WCW'(WORDS - 1);

    assign in_rd_en         = pop;
    assign wr_en            = state_q == WRITE;
    assign sdram_address    = addr_q;
    assign write_data_input = data_q;
    assign frame_done       = frame_done_q;

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        word_cnt_d   = word_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        if (pop) begin
            data_d[{pix_cnt_q, 3'b000} +: 8] = in_dout;
            pix_cnt_d = pix_cnt_q + 4'd1;
            state_d   = pix_cnt_q == 4'd15 ? WRITE : FILL;
        end
        // a held acknowledge only counts once because the FSM leaves WRITE on the first cycle
        if (ack) begin
            state_d      = FILL;
            addr_d       = last_word ? BASE_ADDR : addr_q + 32'd16;
            word_cnt_d   = last_word ? '0 : word_cnt_q + WCW'(1);
            frame_done_d = last_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FILL;
            pix_cnt_q    <= '0;
            word_cnt_q   <= '0;
            addr_q       <= BASE_ADDR;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            word_cnt_q   <= word_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer: scoreboard bench for edge_frame_writer with a two-word frame at 0x1000.
module tb_edge_frame_writer;
    localparam logic [127:0] SEQ = 128'h0F0E0D0C0B0A09080706050403020100;

    logic         clock, reset, in_rd_en, in_empty, wr_en, write_complete, frame_done;
    logic [7:0]   in_dout;
    logic [31:0]  sdram_address;
    logic [127:0] write_data_input;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  next;
        logic [127:0] data;
        logic         last;
        int           len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   ack_delay = 3;
    int   ack_hold = 1;
    logic manual_wc = 1'b0;

    edge_frame_writer #(.WIDTH(16), .HEIGHT(2), .BASE_ADDR(32'h1000)) dut (
        .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
        .in_dout(in_dout), .sdram_address(sdram_address), .wr_en(wr_en),
        .write_data_input(write_data_input), .write_complete(write_complete),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int w);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(w * 37 + i * 11 + 5);
        return r;
    endfunction

    task automatic idle(input int n);
        in_empty = 1'b1;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_pix(input logic [7:0] p);
        int   t = 0;
        logic got = 1'b0;
        in_dout  = p;
        in_empty = 1'b0;
        while (!got && t < 200) begin
            @(negedge clock);
            got = in_rd_en;
            @(posedge clock);
            #1;
            t++;
        end
        if (!got) chk("pop_timeout", 128'(got), 128'd1);
        in_empty = 1'b1;
    endtask

    task automatic send_word(input logic [127:0] d, input int stall, input logic [31:0] a,
                             input logic [31:0] n, input logic l, input int len);
        exp_t e;
        e.addr = a; e.next = n; e.data = d; e.last = l; e.len = len;
        q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            send_pix(d[8*i +: 8]);
            if (stall > 0) idle(stall);
        end
    endtask

    // write_complete responder: rises ack_delay cycles into a write, stays high ack_hold cycles
    initial begin
        int c = 0;
        int h = 0;
        write_complete = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (h > 0) h--;
            else if (wr_en && !reset) c++;
            else c = 0;
            if (h == 0 && c == ack_delay) begin
                h = ack_hold;
                c = 0;
            end
            write_complete = h > 0 || manual_wc;
        end
    end

    // monitor: pops expectations on each new write and follows it to its acknowledge
    initial begin
        exp_t cur;
        logic in_wr = 1'b0;
        logic ack_seen = 1'b0;
        int   hold = 0;
        cur.addr = '0; cur.next = '0; cur.data = '0; cur.last = 1'b0; cur.len = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_wr = 1'b0;
                ack_seen = 1'b0;
                chk("rd_en_in_reset", 128'(in_rd_en), 128'd0);
                continue;
            end
            if (ack_seen) begin
                ack_seen = 1'b0;
                chk("wr_en_after_ack", 128'(wr_en), 128'd0);
                chk("frame_done_after_ack", 128'(frame_done), 128'(cur.last));
                chk("addr_after_ack", 128'(sdram_address), 128'(cur.next));
                if (cur.len != 0) chk("wr_en_cycles", 128'(hold), 128'(cur.len));
            end else if (frame_done) chk("frame_done_spurious", 128'(frame_done), 128'd0);
            if (wr_en && !in_wr) begin
                if (q.size() == 0) chk("unexpected_write", 128'(wr_en), 128'd0);
                else begin
                    cur = q.pop_front();
                    chk("write_addr", 128'(sdram_address), 128'(cur.addr));
                    chk("write_data", write_data_input, cur.data);
                end
                in_wr = 1'b1;
                hold = 0;
            end
            if (wr_en) begin
                hold++;
                chk("addr_stable", 128'(sdram_address), 128'(cur.addr));
                chk("data_stable", write_data_input, cur.data);
                chk("rd_en_in_write", 128'(in_rd_en), 128'd0);
                if (write_complete) begin
                    ack_seen = 1'b1;
                    in_wr = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_empty = 1'b1; in_dout = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        in_empty = 1'b0;
        @(negedge clock);
        chk("reset_rd_en", 128'(in_rd_en), 128'd0);
        chk("reset_wr_en", 128'(wr_en), 128'd0);
        chk("reset_addr", 128'(sdram_address), 128'h1000);
        chk("reset_data", write_data_input, 128'd0);
        chk("reset_frame_done", 128'(frame_done), 128'd0);
        @(posedge clock);
        #1;
        reset = 1'b0; in_empty = 1'b1;

        send_word(SEQ, 0, 32'h1000, 32'h1010, 1'b0, 3);
        send_word(SEQ, 1, 32'h1010, 32'h1000, 1'b1, 3);
        send_word(SEQ, 1, 32'h1000, 32'h1010, 1'b0, 3);
        idle(8);

        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        for (int w = 0; w < 4; w++)
            send_word(mk(w), 0, w % 2 ? 32'h1010 : 32'h1000, w % 2 ? 32'h1000 : 32'h1010, 1'(w % 2), 3);

        e.addr = 32'h1000; e.next = 32'h1010; e.data = mk(4); e.last = 1'b0; e.len = 3;
        q.push_back(e);
        for (int i = 0; i < 5; i++) send_pix(e.data[8*i +: 8]);
        idle(1);
        manual_wc = 1'b1;
        idle(1);
        manual_wc = 1'b0;
        idle(2);
        @(negedge clock);
        chk("fill_ack_wr_en", 128'(wr_en), 128'd0);
        chk("fill_ack_addr", 128'(sdram_address), 128'h1000);
        @(posedge clock);
        #1;
        for (int i = 5; i < 16; i++) send_pix(e.data[8*i +: 8]);

        send_word(mk(5), 0, 32'h1010, 32'h1000, 1'b1, 3);
        idle(6);
        ack_hold = 4;
        send_word(mk(6), 0, 32'h1000, 32'h1010, 1'b0, 3);
        idle(10);
        ack_hold = 1;
        @(negedge clock);
        chk("held_ack_addr", 128'(sdram_address), 128'h1010);
        chk("held_ack_wr_en", 128'(wr_en), 128'd0);
        @(posedge clock);
        #1;

        ack_delay = 1000;
        send_word(mk(7), 0, 32'h1010, 32'h1000, 1'b1, 0);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clock);
        chk("abandon_wr_en", 128'(wr_en), 128'd0);
        chk("abandon_addr", 128'(sdram_address), 128'h1000);
        @(posedge clock);
        #1;
        manual_wc = 1'b1;
        idle(1);
        manual_wc = 1'b0;
        idle(2);
        @(negedge clock);
        chk("late_ack_addr", 128'(sdram_address), 128'h1000);
        chk("late_ack_wr_en", 128'(wr_en), 128'd0);
        @(posedge clock);
        #1;
        ack_delay = 3;
        send_word(mk(8), 0, 32'h1000, 32'h1010, 1'b0, 3);

        for (int t = 0; t < 200 && (q.size() != 0 || wr_en); t++) begin
            @(posedge clock);
            #1;
        end
        idle(6);
        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
